sva_seq_engine: RTL and testbench

Parametrised multi-thread evaluator for one SVA-style sequence of NUM_STEPS steps, each step being an optional stall term `[*0:$]` followed by a match term. Every sample strobe starts a new attempt and advances all live attempts in parallel in a single cycle. Attempts that land on the same step are merged, so live attempts never exceed NUM_STEPS and no overflow path is needed. The block sits in the checker layer, fed by the user-clock edge-detect strobe, and reports success/failure pulses with start timestamps and latencies.

---
 rtl/sva_seq_pkg.sv | 44 ++++
 rtl/sva_step_slot.sv | 81 ++++++++
 rtl/sva_seq_engine.sv | 181 ++++++++++++++++++
 tb/tb_sva_seq_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sva_seq_pkg.sv
// Shared types and helpers for the SVA sequence engine: slot record,
// term-hit test, modular age and collision resolution.
package sva_seq_pkg;

    localparam int MAX_W = 32;

    typedef logic [MAX_W-1:0] word_t;

    typedef struct packed {
        logic  active;
        word_t start_ts;
    } slot_t;

    function automatic logic term_hit(input word_t s, input word_t v, input word_t m);
        return ((s ^ v) & m) == '0;
    endfunction

    // Age is taken modulo 2^w so it stays correct across timestamp wrap.
    function automatic word_t age(input word_t now, input word_t start, input int w);
        word_t mask;
        mask = {MAX_W{1'b1}} >> (MAX_W - w);
        return (now - start) & mask;
    endfunction

    function automatic slot_t pick(input slot_t a, input slot_t b, input word_t now,
                                   input int w, input logic oldest);
        word_t age_a;
        word_t age_b;
        slot_t r;
        age_a = age(now, a.start_ts, w);
        age_b = age(now, b.start_ts, w);
        if (!a.active) begin
            r = b;
        end else if (!b.active) begin
            r = a;
        end else if (oldest) begin
            r = (age_a >= age_b) ? a : b;
        end else begin
            r = (age_a <= age_b) ? a : b;
        end
        return r;
    endfunction

endpackage

// File: rtl/sva_step_slot.sv
// One sequence step: evaluates the resident attempt (and, for step 0, the
// newly launched one), emits advance/fail flags and merges arrivals.
module sva_step_slot
    import sva_seq_pkg::*;
#(
    parameter int SIG_W        = 2,
    parameter int TS_W         = 8,
    parameter bit MERGE_OLDEST = 1'b1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clear,
    input  logic             eval,
    input  logic [SIG_W-1:0] sig,
    input  logic [SIG_W-1:0] match_mask,
    input  logic [SIG_W-1:0] match_val,
    input  logic [SIG_W-1:0] stall_mask,
    input  logic [SIG_W-1:0] stall_val,
    input  logic             stall_en,
    input  word_t            ts_now,
    input  slot_t            land_in,
    input  slot_t            extra_in,
    output slot_t            slot_o,
    output slot_t            adv_o,
    output logic             fail_own_o,
    output logic             fail_extra_o,
    output logic             merge_o
);

    slot_t slot_q, slot_d;
    slot_t own, ext, own_adv, ext_adv, own_stay, ext_stay, stay_a, stay;
    logic  m_hit, s_hit;

    always_comb begin
        m_hit = term_hit(word_t'(sig), word_t'(match_val), word_t'(match_mask));
        s_hit = stall_en && term_hit(word_t'(sig), word_t'(stall_val), word_t'(stall_mask));

        own = slot_q;
        own.active = slot_q.active && eval;
        ext = extra_in;
        ext.active = extra_in.active && eval;

        own_adv = own;
        own_adv.active = own.active && m_hit;
        ext_adv = ext;
        ext_adv.active = ext.active && m_hit;
        own_stay = own;
        own_stay.active = own.active && !m_hit && s_hit;
        ext_stay = ext;
        ext_stay.active = ext.active && !m_hit && s_hit;

        fail_own_o   = own.active && !m_hit && !s_hit;
        fail_extra_o = ext.active && !m_hit && !s_hit;

        // Two attempts advancing together collide at the next step; resolve here.
        adv_o  = pick(own_adv, ext_adv, ts_now, TS_W, MERGE_OLDEST);
        stay_a = pick(land_in, own_stay, ts_now, TS_W, MERGE_OLDEST);
        stay   = pick(stay_a, ext_stay, ts_now, TS_W, MERGE_OLDEST);

        merge_o = (own_adv.active && ext_adv.active) ||
                  ((2'(land_in.active) + 2'(own_stay.active) + 2'(ext_stay.active)) > 2'd1);

        slot_d = slot_q;
        if (clear) begin
            slot_d = '0;
        end else if (eval) begin
            slot_d = stay;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/sva_seq_engine.sv
// Multi-thread SVA sequence evaluator: timestamp counter, per-step slots,
// success reporting, fail popcount with oldest-fail selection.
module sva_seq_engine
    import sva_seq_pkg::*;
#(
    parameter int SIG_W         = 2,
    parameter int NUM_STEPS     = 2,
    parameter int TS_W          = 8,
    parameter bit VACUOUS_START = 1'b1,
    parameter bit MERGE_OLDEST  = 1'b1,
    localparam int FN_W = $clog2(NUM_STEPS + 2),
    localparam int FS_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       clear,
    input  logic                       sample_en,
    input  logic                       start_en,
    input  logic [SIG_W-1:0]           sig,
    input  logic [NUM_STEPS*SIG_W-1:0] match_mask,
    input  logic [NUM_STEPS*SIG_W-1:0] match_val,
    input  logic [NUM_STEPS*SIG_W-1:0] stall_mask,
    input  logic [NUM_STEPS*SIG_W-1:0] stall_val,
    input  logic [NUM_STEPS-1:0]       stall_en,
    output logic                       succ,
    output logic [TS_W-1:0]            succ_ts,
    output logic [TS_W-1:0]            succ_lat,
    output logic                       fail,
    output logic [FN_W-1:0]            fail_num,
    output logic [TS_W-1:0]            fail_ts,
    output logic [FS_W-1:0]            fail_step,
    output logic                       merge,
    output logic [NUM_STEPS-1:0]       active_vec,
    output logic                       busy
);

    logic [TS_W-1:0] ts_q, ts_d;
    logic            eval;
    word_t           ts_w;
    slot_t           new_att;
    slot_t           cur [NUM_STEPS];
    slot_t           adv [NUM_STEPS];
    logic [NUM_STEPS-1:0] fail_own, fail_extra, merge_k;

    logic            succ_q, succ_d, fail_q, fail_d, merge_q, merge_d;
    logic [TS_W-1:0] succ_ts_q, succ_ts_d, succ_lat_q, succ_lat_d, fail_ts_q, fail_ts_d;
    logic [FN_W-1:0] fail_num_q, fail_num_d, cnt;
    logic [FS_W-1:0] fail_step_q, fail_step_d, best_step;
    logic [TS_W-1:0] best_ts;
    word_t           best_age, a;
    logic            best_found;

    assign eval    = sample_en && !clear;
    assign ts_w    = word_t'(ts_q);
    assign new_att = '{active: eval && start_en, start_ts: ts_w};

    for (genvar k = 0; k < NUM_STEPS; k++) begin : g_step
        slot_t land_in, extra_in;
        if (k == 0) begin : g_first
            assign land_in  = '0;
            assign extra_in = new_att;
        end else begin : g_rest
            assign land_in  = adv[k-1];
            assign extra_in = '0;
        end
        sva_step_slot #(
            .SIG_W(SIG_W), .TS_W(TS_W), .MERGE_OLDEST(MERGE_OLDEST)
        ) u_slot (
            .sys_clk      (sys_clk),
            .sys_rst_n    (sys_rst_n),
            .clear        (clear),
            .eval         (eval),
            .sig          (sig),
            .match_mask   (match_mask[k*SIG_W +: SIG_W]),
            .match_val    (match_val[k*SIG_W +: SIG_W]),
            .stall_mask   (stall_mask[k*SIG_W +: SIG_W]),
            .stall_val    (stall_val[k*SIG_W +: SIG_W]),
            .stall_en     (stall_en[k]),
            .ts_now       (ts_w),
            .land_in      (land_in),
            .extra_in     (extra_in),
            .slot_o       (cur[k]),
            .adv_o        (adv[k]),
            .fail_own_o   (fail_own[k]),
            .fail_extra_o (fail_extra[k]),
            .merge_o      (merge_k[k])
        );
        assign active_vec[k] = cur[k].active;
    end

    always_comb begin
        ts_d = ts_q;
        if (clear) begin
            ts_d = '0;
        end else if (sample_en) begin
            ts_d = ts_q + TS_W'(1);
        end

        succ_d     = adv[NUM_STEPS-1].active;
        succ_ts_d  = succ_ts_q;
        succ_lat_d = succ_lat_q;
        if (succ_d) begin
            succ_ts_d  = adv[NUM_STEPS-1].start_ts[TS_W-1:0];
            succ_lat_d = TS_W'(age(ts_w, adv[NUM_STEPS-1].start_ts, TS_W));
        end

        cnt        = '0;
        best_found = 1'b0;
        best_age   = '0;
        best_ts    = '0;
        best_step  = '0;
        a          = '0;
        for (int k = 0; k < NUM_STEPS; k++) begin
            if (fail_own[k]) begin
                cnt = cnt + FN_W'(1);
                a   = age(ts_w, cur[k].start_ts, TS_W);
                if (!best_found || a > best_age) begin
                    best_found = 1'b1;
                    best_age   = a;
                    best_ts    = cur[k].start_ts[TS_W-1:0];
                    best_step  = FS_W'(k);
                end
            end
        end
        // The fresh attempt is the youngest, so it is reported only when alone.
        if (!VACUOUS_START && fail_extra[0]) begin
            cnt = cnt + FN_W'(1);
            if (!best_found) begin
                best_ts   = ts_q;
                best_step = '0;
            end
        end

        fail_d      = cnt != '0;
        fail_num_d  = fail_num_q;
        fail_ts_d   = fail_ts_q;
        fail_step_d = fail_step_q;
        if (fail_d) begin
            fail_num_d  = cnt;
            fail_ts_d   = best_ts;
            fail_step_d = best_step;
        end

        merge_d = |merge_k;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ts_q        <= '0;
            succ_q      <= 1'b0;
            succ_ts_q   <= '0;
            succ_lat_q  <= '0;
            fail_q      <= 1'b0;
            fail_num_q  <= '0;
            fail_ts_q   <= '0;
            fail_step_q <= '0;
            merge_q     <= 1'b0;
        end else begin
            ts_q        <= ts_d;
            succ_q      <= succ_d;
            succ_ts_q   <= succ_ts_d;
            succ_lat_q  <= succ_lat_d;
            fail_q      <= fail_d;
            fail_num_q  <= fail_num_d;
            fail_ts_q   <= fail_ts_d;
            fail_step_q <= fail_step_d;
            merge_q     <= merge_d;
        end
    end

    assign succ      = succ_q;
    assign succ_ts   = succ_ts_q;
    assign succ_lat  = succ_lat_q;
    assign fail      = fail_q;
    assign fail_num  = fail_num_q;
    assign fail_ts   = fail_ts_q;
    assign fail_step = fail_step_q;
    assign merge     = merge_q;
    assign busy      = |active_vec;

endmodule

// File: tb/tb_sva_seq_engine.sv
// Scoreboard bench: three engine configurations, directed samples with
// hand-computed expected pulses queued per instance and checked by a monitor.
module tb_sva_seq_engine;

    typedef struct packed {
        logic       succ;
        logic [7:0] succ_ts;
        logic [7:0] succ_lat;
        logic       fail;
        logic [1:0] fail_num;
        logic [7:0] fail_ts;
        logic [0:0] fail_step;
        logic       merge;
    } resp_t;

    localparam logic [1:0] CB   = 2'b11;
    localparam logic [1:0] CNB  = 2'b10;
    localparam logic [1:0] NONE = 2'b00;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b1;
    logic clear = 1'b0;
    logic se_ab = 1'b0, st_ab = 1'b0, se_c = 1'b0, st_c = 1'b0;
    logic [1:0] sig_ab = 2'b00, sig_c = 2'b00;

    logic       a_succ, b_succ, c_succ, a_fail, b_fail, c_fail, a_merge, b_merge, c_merge;
    logic [7:0] a_sts, b_sts, c_sts, a_slat, b_slat, c_slat, a_fts, b_fts, c_fts;
    logic [1:0] a_fnum, b_fnum, c_fnum, a_act, b_act;
    logic [0:0] a_fstep, b_fstep, c_fstep, c_act;
    logic       a_busy, b_busy, c_busy;

    resp_t r_a, r_b, r_c;
    resp_t q_a[$], q_b[$], q_c[$];
    int n_tests = 0;
    int n_fail = 0;

    assign r_a = {a_succ, a_sts, a_slat, a_fail, a_fnum, a_fts, a_fstep, a_merge};
    assign r_b = {b_succ, b_sts, b_slat, b_fail, b_fnum, b_fts, b_fstep, b_merge};
    assign r_c = {c_succ, c_sts, c_slat, c_fail, c_fnum, c_fts, c_fstep, c_merge};

    always #5 sys_clk = ~sys_clk;

    sva_seq_engine #(.SIG_W(2), .NUM_STEPS(2), .TS_W(8), .VACUOUS_START(1'b0), .MERGE_OLDEST(1'b1)) u_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clear(clear), .sample_en(se_ab), .start_en(st_ab),
        .sig(sig_ab), .match_mask(4'b1111), .match_val(4'b1111), .stall_mask(4'b1111),
        .stall_val(4'b1010), .stall_en(2'b11), .succ(a_succ), .succ_ts(a_sts), .succ_lat(a_slat),
        .fail(a_fail), .fail_num(a_fnum), .fail_ts(a_fts), .fail_step(a_fstep), .merge(a_merge),
        .active_vec(a_act), .busy(a_busy));

    sva_seq_engine #(.SIG_W(2), .NUM_STEPS(2), .TS_W(8), .VACUOUS_START(1'b0), .MERGE_OLDEST(1'b0)) u_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clear(clear), .sample_en(se_ab), .start_en(st_ab),
        .sig(sig_ab), .match_mask(4'b1111), .match_val(4'b1111), .stall_mask(4'b1111),
        .stall_val(4'b1010), .stall_en(2'b11), .succ(b_succ), .succ_ts(b_sts), .succ_lat(b_slat),
        .fail(b_fail), .fail_num(b_fnum), .fail_ts(b_fts), .fail_step(b_fstep), .merge(b_merge),
        .active_vec(b_act), .busy(b_busy));

    sva_seq_engine #(.SIG_W(2), .NUM_STEPS(1), .TS_W(8), .VACUOUS_START(1'b1), .MERGE_OLDEST(1'b1)) u_c (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clear(clear), .sample_en(se_c), .start_en(st_c),
        .sig(sig_c), .match_mask(2'b10), .match_val(2'b10), .stall_mask(2'b00),
        .stall_val(2'b00), .stall_en(1'b0), .succ(c_succ), .succ_ts(c_sts), .succ_lat(c_slat),
        .fail(c_fail), .fail_num(c_fnum), .fail_ts(c_fts), .fail_step(c_fstep), .merge(c_merge),
        .active_vec(c_act), .busy(c_busy));

    function automatic resp_t mk(input logic s, input logic [7:0] sts, input logic [7:0] slat,
                                 input logic f, input logic [1:0] fn, input logic [7:0] fts,
                                 input logic fstep, input logic m);
        return {s, sts, slat, f, fn, fts, fstep, m};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp(input string nm, input resp_t a, input resp_t e);
        logic ok;
        n_tests++;
        ok = (a.succ == e.succ) && (a.fail == e.fail) && (a.merge == e.merge);
        if (e.succ) ok = ok && (a.succ_ts == e.succ_ts) && (a.succ_lat == e.succ_lat);
        if (e.fail) ok = ok && (a.fail_num == e.fail_num) && (a.fail_ts == e.fail_ts) &&
                         (a.fail_step == e.fail_step);
        if (!ok) begin
            n_fail++;
            $display("FAIL %s pulse: got succ=%0d ts=%0d lat=%0d fail=%0d num=%0d fts=%0d fstep=%0d merge=%0d; expected succ=%0d ts=%0d lat=%0d fail=%0d num=%0d fts=%0d fstep=%0d merge=%0d",
                     nm, a.succ, a.succ_ts, a.succ_lat, a.fail, a.fail_num, a.fail_ts, a.fail_step, a.merge,
                     e.succ, e.succ_ts, e.succ_lat, e.fail, e.fail_num, e.fail_ts, e.fail_step, e.merge);
        end
    endtask

    task automatic unexpected(input string nm, input resp_t a);
        n_tests++;
        n_fail++;
        $display("FAIL %s unexpected pulse: got succ=%0d fail=%0d merge=%0d, expected no pulse",
                 nm, a.succ, a.fail, a.merge);
    endtask

    // Monitor: every pulse cycle consumes one expected record.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (r_a.succ || r_a.fail || r_a.merge) begin
                if (q_a.size() == 0) unexpected("A", r_a);
                else cmp("A", r_a, q_a.pop_front());
            end
            if (r_b.succ || r_b.fail || r_b.merge) begin
                if (q_b.size() == 0) unexpected("B", r_b);
                else cmp("B", r_b, q_b.pop_front());
            end
            if (r_c.succ || r_c.fail || r_c.merge) begin
                if (q_c.size() == 0) unexpected("C", r_c);
                else cmp("C", r_c, q_c.pop_front());
            end
        end
    end

    task automatic ab(input logic st, input logic [1:0] s);
        @(negedge sys_clk);
        se_ab = 1'b1; st_ab = st; sig_ab = s;
        @(posedge sys_clk);
        #1;
        se_ab = 1'b0; st_ab = 1'b0;
    endtask

    task automatic cs(input logic st, input logic [1:0] s);
        @(negedge sys_clk);
        se_c = 1'b1; st_c = st; sig_c = s;
        @(posedge sys_clk);
        #1;
        se_c = 1'b0; st_c = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge sys_clk);
        clear = 1'b1;
        @(posedge sys_clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic push_ab(input resp_t e);
        q_a.push_back(e);
        q_b.push_back(e);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_a"}, {r_a, a_act, a_busy}, 64'd0);
        chk({nm, "_b"}, {r_b, b_act, b_busy}, 64'd0);
        chk({nm, "_c"}, {r_c, c_act, c_busy}, 64'd0);
    endtask

    initial begin
        #2 sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1 chk_zero("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // basic 4-sample success right after reset (ts starts at 0)
        ab(1'b1, CB);
        chk("t1_act_s0", a_act, 2'b10);
        ab(1'b0, CNB);
        ab(1'b0, CNB);
        push_ab(mk(1, 8'd0, 8'd3, 0, 2'd0, 8'd0, 0, 0));
        ab(1'b0, CB);
        chk("t1_act_end", a_act, 2'b00);

        // repeated stalling starts merge in slot 0
        do_clear();
        ab(1'b1, CNB);
        chk("t2_act_s0", a_act, 2'b01);
        for (int i = 1; i < 4; i++) begin
            push_ab(mk(0, 8'd0, 8'd0, 0, 2'd0, 8'd0, 0, 1));
            ab(1'b1, CNB);
            chk("t2_act_a", a_act, 2'b01);
            chk("t2_act_b", b_act, 2'b01);
        end
        ab(1'b0, CB);
        chk("t2_act_adv", a_act, 2'b10);
        q_a.push_back(mk(1, 8'd0, 8'd5, 0, 2'd0, 8'd0, 0, 0));
        q_b.push_back(mk(1, 8'd3, 8'd2, 0, 2'd0, 8'd0, 0, 0));
        ab(1'b0, CB);

        // both slots plus a new attempt fail together
        do_clear();
        ab(1'b1, CB);
        ab(1'b1, CNB);
        chk("t3_act_both", a_act, 2'b11);
        push_ab(mk(0, 8'd0, 8'd0, 1, 2'd3, 8'd0, 1, 0));
        ab(1'b1, NONE);
        chk("t3_act_after", a_act, 2'b00);

        // same, without a new attempt on the failing sample
        do_clear();
        ab(1'b1, CB);
        ab(1'b1, CNB);
        push_ab(mk(0, 8'd0, 8'd0, 1, 2'd2, 8'd0, 1, 0));
        ab(1'b0, NONE);
        chk("t3b_busy", a_busy, 1'b0);

        // single-step sequence: zero-latency success, vacuous start dropped
        do_clear();
        q_c.push_back(mk(1, 8'd0, 8'd0, 0, 2'd0, 8'd0, 0, 0));
        cs(1'b1, 2'b10);
        chk("t4_succ_now", c_succ, 1'b1);
        cs(1'b1, 2'b00);
        chk("t4_vacuous", c_fail, 1'b0);
        q_c.push_back(mk(1, 8'd2, 8'd0, 0, 2'd0, 8'd0, 0, 0));
        cs(1'b1, 2'b11);
        cs(1'b0, 2'b10);
        chk("t4_act", c_act, 1'b0);

        // clear together with a sample: clear wins, nothing reported
        do_clear();
        ab(1'b1, CB);
        ab(1'b1, CNB);
        chk("t5_act_pre", a_act, 2'b11);
        @(negedge sys_clk);
        clear = 1'b1; se_ab = 1'b1; st_ab = 1'b1; sig_ab = NONE;
        @(posedge sys_clk);
        #1;
        clear = 1'b0; se_ab = 1'b0; st_ab = 1'b0;
        chk("t5_act_clr", a_act, 2'b00);
        chk("t5_no_fail", a_fail, 1'b0);
        ab(1'b1, CB);
        push_ab(mk(1, 8'd0, 8'd1, 0, 2'd0, 8'd0, 0, 0));
        ab(1'b0, CB);

        // asynchronous reset in the middle of an attempt
        ab(1'b1, CB);
        ab(1'b1, CNB);
        chk("t6_act_pre", a_act, 2'b11);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1 chk_zero("t6_async");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        ab(1'b1, CB);
        ab(1'b0, CNB);
        ab(1'b0, CNB);
        push_ab(mk(1, 8'd0, 8'd3, 0, 2'd0, 8'd0, 0, 0));
        ab(1'b0, CB);

        repeat (3) @(negedge sys_clk);
        #1;
        chk("q_a_drained", 64'(q_a.size()), 64'd0);
        chk("q_b_drained", 64'(q_b.size()), 64'd0);
        chk("q_c_drained", 64'(q_c.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected the bench to finish");
        $fatal(1, "watchdog");
    end

endmodule
